// File: rtl/apb_bus_arbiter.sv
// apb_bus_arbiter: two-requester round-robin arbiter in front of the peripheral APB node.
// Grants one transfer at a time, replays it to the node as registered SETUP/ACCESS phases,
// and routes the node response back to the owner in the same cycle as m_pready_i.
// Optional build macro: APB_ARB_TIMEOUT_EN bounds ACCESS at TIMEOUT_CYCLES cycles and then
// answers the owner with PSLVERR.
module apb_bus_arbiter #(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [1:0]                    r_psel_i,
    input  logic [1:0]                    r_penable_i,
    input  logic [1:0]                    r_pwrite_i,
    input  logic [2*APB_ADDR_WIDTH-1:0]   r_paddr_i,
    input  logic [2*APB_DATA_WIDTH-1:0]   r_pwdata_i,
    output logic [2*APB_DATA_WIDTH-1:0]   r_prdata_o,
    output logic [1:0]                    r_pready_o,
    output logic [1:0]                    r_pslverr_o,
    output logic                          m_psel_o,
    output logic                          m_penable_o,
    output logic                          m_pwrite_o,
    output logic [APB_ADDR_WIDTH-1:0]     m_paddr_o,
    output logic [APB_DATA_WIDTH-1:0]     m_pwdata_o,
    input  logic [APB_DATA_WIDTH-1:0]     m_prdata_i,
    input  logic                          m_pready_i,
    input  logic                          m_pslverr_i,
    output logic [1:0]                    grant_o,
    output logic                          busy_o
);

    localparam int unsigned AW = APB_ADDR_WIDTH;
    localparam int unsigned DW = APB_DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t         state_q;
    logic           ptr_q;      // preferred requester for the next arbitration
    logic           own_q;      // index of the current owner
    logic           win_c;
    logic           timeout_c;
    logic           done_c;
    logic [DW-1:0]  rdata_c;
    logic           unused_ok;

    // PENABLE from the requesters carries no information for arbitration
    assign unused_ok = ^{r_penable_i, 1'(TIMEOUT_CYCLES)};

    // Round-robin winner: preferred requester if it asks, otherwise the other one
    always_comb begin
        win_c = r_psel_i[ptr_q] ? ptr_q : ~ptr_q;
    end

`ifdef APB_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] to_cnt_q;

    // Counts ACCESS cycles the node has left unanswered in the current transfer
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            to_cnt_q <= '0;
        end else if (state_q == ST_SETUP) begin
            to_cnt_q <= '0;
        end else if (state_q == ST_ACCESS && !m_pready_i) begin
            to_cnt_q <= to_cnt_q + CW'(1);
        end
    end

    // Terminal ACCESS cycle without node response; a late PREADY still wins
    assign timeout_c = (state_q == ST_ACCESS) && !m_pready_i &&
                       (to_cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_c = 1'b0;
`endif

    assign done_c = (state_q == ST_ACCESS) && (m_pready_i || timeout_c);

    // Same-cycle response routing to the owner; the other requester sees zeros
    always_comb begin
        r_pready_o  = '0;
        r_pslverr_o = '0;
        r_prdata_o  = '0;
        rdata_c     = '0;
        if (done_c) begin
            r_pready_o[own_q] = 1'b1;
            if (m_pready_i) begin
                r_pslverr_o[own_q] = m_pslverr_i;
                rdata_c            = m_prdata_i;
            end else begin
                r_pslverr_o[own_q] = 1'b1;
            end
            if (own_q) begin
                r_prdata_o[2*DW-1:DW] = rdata_c;
            end else begin
                r_prdata_o[DW-1:0] = rdata_c;
            end
        end
    end

    // Arbitration FSM with registered node-side and status outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 1'b0;
            own_q       <= 1'b0;
            m_psel_o    <= 1'b0;
            m_penable_o <= 1'b0;
            m_pwrite_o  <= 1'b0;
            m_paddr_o   <= '0;
            m_pwdata_o  <= '0;
            grant_o     <= '0;
            busy_o      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|r_psel_i) begin
                        own_q      <= win_c;
                        grant_o    <= win_c ? 2'b10 : 2'b01;
                        m_pwrite_o <= r_pwrite_i[win_c];
                        m_paddr_o  <= win_c ? r_paddr_i[2*AW-1:AW]  : r_paddr_i[AW-1:0];
                        m_pwdata_o <= win_c ? r_pwdata_i[2*DW-1:DW] : r_pwdata_i[DW-1:0];
                        m_psel_o   <= 1'b1;
                        busy_o     <= 1'b1;
                        state_q    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    m_penable_o <= 1'b1;
                    state_q     <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (done_c) begin
                        m_psel_o    <= 1'b0;
                        m_penable_o <= 1'b0;
                        grant_o     <= '0;
                        busy_o      <= 1'b0;
                        ptr_q       <= ~own_q;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    m_psel_o    <= 1'b0;
                    m_penable_o <= 1'b0;
                    grant_o     <= '0;
                    busy_o      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
